// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core: decodes the IR opcode and
// steps the shared datapath through fetch/decode/execute/memory/writeback.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_instrCount;

  logic       w_memReq;
  logic       w_pcUpdate;
  logic       w_branch;
  logic       w_adrSrc;
  logic       w_memWrite;
  logic       w_irWrite;
  logic [1:0] w_resultSrc;
  logic [1:0] w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [1:0] w_immSrc;
  logic [1:0] w_aluOp;
  logic [2:0] w_aluControl;
  logic       w_regWrite;
  logic       w_illegal;
  logic       w_retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_memReq    = 1'b0;
    w_pcUpdate  = 1'b0;
    w_branch    = 1'b0;
    w_adrSrc    = 1'b0;
    w_memWrite  = 1'b0;
    w_irWrite   = 1'b0;
    w_resultSrc = 2'b00;
    w_aluSrcA   = 2'b00;
    w_aluSrcB   = 2'b00;
    w_immSrc    = 2'b00;
    w_aluOp     = ALUOP_ADD;
    w_regWrite  = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq    = 1'b1;
        w_aluSrcB   = 2'b10;
        w_resultSrc = 2'b10;
        if (mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcUpdate  = 1'b1;
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        w_aluSrcA = 2'b01;
        w_aluSrcB = 2'b01;
        w_immSrc  = 2'b10;
        case (op)
          OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
          OP_RTYPE:          w_nextState = S_EXECR;
          OP_ITYPE:          w_nextState = S_EXECI;
          OP_BRANCH:         w_nextState = S_BEQ;
          OP_JAL:            w_nextState = S_JAL;
          default: begin
            w_illegal   = 1'b1;
            w_nextState = S_FETCH;
          end
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR: begin
        w_aluSrcA   = 2'b10;
        w_aluSrcB   = 2'b01;
        w_immSrc    = op[5] ? 2'b01 : 2'b00;
        w_nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memReq = 1'b1;
        w_adrSrc = 1'b1;
        if (mem_ready) begin
          w_nextState = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_resultSrc = 2'b01;
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memReq   = 1'b1;
        w_adrSrc   = 1'b1;
        w_memWrite = 1'b1;
        if (mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_EXECR: begin
        w_aluSrcA   = 2'b10;
        w_aluOp     = ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_EXECI: begin
        w_aluSrcA   = 2'b10;
        w_aluSrcB   = 2'b01;
        w_aluOp     = ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_ALUWB: begin
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
      S_BEQ: begin
        w_aluSrcA   = 2'b10;
        w_aluOp     = ALUOP_SUB;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
      S_JAL: begin
        w_aluSrcA   = 2'b01;
        w_aluSrcB   = 2'b10;
        w_immSrc    = 2'b11;
        w_pcUpdate  = 1'b1;
        w_nextState = S_ALUWB;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  always_comb begin
    w_aluControl = 3'b000;
    case (w_aluOp)
      ALUOP_SUB: w_aluControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  w_aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_aluControl = 3'b101;
          3'b110:  w_aluControl = 3'b011;
          3'b111:  w_aluControl = 3'b010;
          default: w_aluControl = 3'b000;
        endcase
      end
      default: w_aluControl = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instrCount <= '0;
    end else if (w_retire) begin
      r_instrCount <= r_instrCount + 1'b1;
    end
  end

  // Outputs are gated by rst so that a mid-access reset drops them without waiting for a clock
  assign mem_req     = rst & w_memReq;
  assign PCWrite     = rst & (w_pcUpdate | (w_branch & Zero));
  assign AdrSrc      = rst & w_adrSrc;
  assign MemWrite    = rst & w_memWrite;
  assign IRWrite     = rst & w_irWrite;
  assign ResultSrc   = rst ? w_resultSrc : 2'b00;
  assign ALUSrcA     = rst ? w_aluSrcA : 2'b00;
  assign ALUSrcB     = rst ? w_aluSrcB : 2'b00;
  assign ImmSrc      = rst ? w_immSrc : 2'b00;
  assign ALUControl  = rst ? w_aluControl : 3'b000;
  assign RegWrite    = rst & w_regWrite;
  assign illegal     = rst & w_illegal;
  assign instr_count = rst ? r_instrCount : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction cycle sequences are predicted
// from the opcode and stall pattern, queued, and compared cycle by cycle by a monitor.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             Zero;
  logic             mem_ready;
  logic             mem_req;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [2:0]       ALUControl;
  logic             RegWrite;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [17:0]      dutWord;

  typedef struct {
    logic [17:0]      word;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t expQ[$];
  int   checks     = 0;
  int   failures   = 0;
  int   modelCount = 0;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  assign dutWord = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};

  always #5 clk = ~clk;

  // Control word layout mirrors dutWord so a single compare covers every output
  function automatic logic [17:0] cw(input logic memReq, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic [1:0] res,
                                     input logic [1:0] srcA, input logic [1:0] srcB,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic rw, input logic ill);
    return {memReq, pcw, adr, mw, irw, res, srcA, srcB, imm, alu, rw, ill};
  endfunction

  function automatic logic isLegal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  function automatic logic [2:0] expAlu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic [17:0] w, input int c);
    exp_t e;
    e.word  = w;
    e.count = CNT_W'(c);
    expQ.push_back(e);
  endtask

  task automatic driveCycle(input logic ready, input logic [6:0] opv, input logic [2:0] f3,
                            input logic f7, input logic z, input logic [17:0] w);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = ready;
    op        = opv;
    funct3    = f3;
    funct7b5  = f7;
    Zero      = z;
    pushExp(w, modelCount);
  endtask

  task automatic resetMidAccess();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    pushExp(18'd0, 0);
    #1;
    rst = 1'b0;
    modelCount = 0;
    #1;
    checkOutput("asyncResetWord", 32'(dutWord), 32'd0);
    checkOutput("asyncResetCount", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    pushExp(18'd0, 0);
  endtask

  // zeroSel < 0 randomises Zero; resetAt >= 0 pulls rst low at that memory stall cycle
  task automatic applyStimulus(input logic [6:0] opv, input logic [2:0] f3, input logic f7,
                               input int fetchStalls, input int memStalls,
                               input int zeroSel, input int resetAt);
    logic        z;
    logic [17:0] stallWord;
    for (int k = 0; k < fetchStalls; k++)
      driveCycle(1'b0, 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                 cw(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    driveCycle(1'b1, 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               cw(1, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
               cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, !isLegal(opv)));
    if (!isLegal(opv)) return;
    case (opv)
      OP_LW, OP_SW: begin
        driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                   cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, (opv == OP_SW) ? 2'b01 : 2'b00, 3'b000, 0, 0));
        stallWord = cw(1, 0, 1, (opv == OP_SW), 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        for (int k = 0; k < memStalls; k++) begin
          if (k == resetAt) begin
            resetMidAccess();
            return;
          end
          driveCycle(1'b0, opv, f3, f7, 1'($urandom), stallWord);
        end
        driveCycle(1'b1, opv, f3, f7, 1'($urandom), stallWord);
        if (opv == OP_LW)
          driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                     cw(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      end
      OP_R, OP_I: begin
        driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                   cw(0, 0, 0, 0, 0, 2'b00, 2'b10, (opv == OP_I) ? 2'b01 : 2'b00, 2'b00,
                      expAlu(opv, f3, f7), 0, 0));
        driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                   cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      end
      OP_BEQ: begin
        z = (zeroSel < 0) ? 1'($urandom) : 1'(zeroSel);
        driveCycle(1'($urandom), opv, f3, f7, z,
                   cw(0, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0, 0));
      end
      default: begin
        driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                   cw(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));
        driveCycle(1'($urandom), opv, f3, f7, 1'($urandom),
                   cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
      end
    endcase
    modelCount = (modelCount + 1) % (1 << CNT_W);
  endtask

  always @(negedge clk) begin : monitorBlk
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("ctrlWord", 32'(dutWord), 32'(e.word));
      checkOutput("instrCount", 32'(instr_count), 32'(e.count));
    end
  end

  initial begin
    logic [6:0] rop;
    rst       = 1'b0;
    op        = 7'd0;
    funct3    = 3'd0;
    funct7b5  = 1'b0;
    Zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    checkOutput("resetWord", 32'(dutWord), 32'd0);
    checkOutput("resetCount", 32'(instr_count), 32'd0);

    applyStimulus(OP_LW, 3'b010, 1'b0, 2, 2, -1, -1);
    applyStimulus(OP_SW, 3'b010, 1'b0, 0, 0, -1, -1);
    applyStimulus(OP_R, 3'b000, 1'b1, 0, 0, -1, -1);
    applyStimulus(OP_R, 3'b000, 1'b0, 0, 0, -1, -1);
    applyStimulus(OP_I, 3'b000, 1'b1, 0, 0, -1, -1);
    applyStimulus(OP_R, 3'b111, 1'b0, 0, 0, -1, -1);
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 0, 0, 1, -1);
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 0, 0, 0, -1);
    applyStimulus(OP_BAD, 3'b000, 1'b0, 0, 0, -1, -1);
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1, 0, -1, -1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_BEQ;
        5: rop = OP_JAL;
        default: begin
          rop = 7'($urandom);
          if (isLegal(rop)) rop = OP_BAD;
        end
      endcase
      applyStimulus(rop, 3'($urandom), 1'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), -1, -1);
    end

    applyStimulus(OP_SW, 3'b010, 1'b0, 0, 3, -1, 1);
    applyStimulus(OP_LW, 3'b010, 1'b0, 1, 1, -1, -1);

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencer for the multi-cycle RV32I core.
- Decodes the opcode held in the instruction register and steps the shared datapath (PC, memory port, ALU, register file, immediate extender) through fetch/decode/execute/memory/writeback.
- Drives ImmSrc to the immediate extender, paces the unified memory port with a req/ready handshake, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- op  in  7  opcode, IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address mux: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe, valid with mem_req
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- illegal  out  1  pulses 1 cycle on unsupported opcode
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async)
  - State goes to FETCH; instr_count clears to 0.
  - All outputs are forced to 0 while rst=0, regardless of state.
  - Reset release resumes in FETCH.
- Outputs are Moore-decoded from the state register, except the ready-gated strobes and PCWrite.
- PCWrite = PCUpdate | (Branch & Zero).
- Default for every output not listed in a state: 0.
- FETCH
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only in the cycle mem_ready=1; that same edge moves to DECODE.
  - While mem_ready=0, stay in FETCH with mem_req held high.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (branch target precompute).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH with illegal=1 for this cycle; not counted.
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for lw, 01 for sw.
  - Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD
  - Outputs: mem_req=1, AdrSrc=1, ResultSrc=00.
  - Hold until mem_ready=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE
  - Outputs: mem_req=1, AdrSrc=1, MemWrite=1, held until mem_ready=1.
  - Then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=funct -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1.
  - PCWrite=Zero.
  - -> FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1, ImmSrc=11.
  - -> ALUWB.
- ALU decode for ALUOp=funct, by funct3:
  - 000: sub if (op[5] & funct7b5), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Others: add.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - JAL counts at its ALUWB.
  - Wraps modulo 2^CNT_W.
- A memory stall has no time limit; the state is held with all outputs stable.
- Reset asserted mid-access drops mem_req/MemWrite immediately (asynchronously).

Test Plan:
- lw, op=0000011, mem_ready low 2 cycles in FETCH and in MEMREAD -> states FETCH(x3), DECODE, MEMADR (ImmSrc=00), MEMREAD(x3), MEMWB with RegWrite=1, ResultSrc=01; IRWrite high exactly 1 cycle; instr_count 0->1.
- sw, op=0100011, mem_ready=1 -> MEMADR shows ImmSrc=01; MEMWRITE shows mem_req=1, MEMWrite=1, AdrSrc=1 for 1 cycle; RegWrite never 1; count +1.
- R-type, funct3=000, funct7b5=1 -> EXECR ALUControl=001; same with funct7b5=0 -> 000; addi with funct7b5=1 -> 000; funct3=111 -> 010.
- beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both retire (count +1).
- op=1111111 -> illegal=1 in the DECODE cycle, return to FETCH, count unchanged.
- rst pulled low during MEMWRITE stall -> all outputs 0 the same cycle; count=0; after release, FETCH with mem_req=1.
